// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the KGP multi-cycle sequencer: state codes, the
// captured control-decode bundle and small elaboration helpers.
package exec_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_PAUSE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Control-unit decode captured in EXEC and replayed in MEM/WB.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
    } ctl_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exec_sequencer_cont_edge_det.sv
// Button rising-edge detector; the history flop resets high so a button held
// through reset never produces a pulse.
module cont_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP datapath with
// registered per-stage strobes, single-step/halt control and a retired counter.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cont,
    input  logic             halt_req,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    output logic             imem_en,
    output logic             ir_load,
    output logic             dmem_en,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             out_we,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int                WAIT_W     = $clog2(max_int(IMEM_LAT, DMEM_LAT)) + 1;
    localparam logic [WAIT_W-1:0] FETCH_LAST = WAIT_W'(IMEM_LAT - 1);
    localparam logic [WAIT_W-1:0] MEM_LAST   = WAIT_W'(DMEM_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_t            cur_state;
    logic [WAIT_W-1:0] wait_cnt;
    ctl_t              ctl_q;
    logic              cont_edge;

    cont_edge_det u_cont_edge (
        .clk   (clk),
        .rst   (rst),
        .level (cont),
        .pulse (cont_edge)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Every strobe is a flop set on the edge that enters the state it belongs
    // to, so outputs never see a combinational path from any input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state   <= S_FETCH;
            wait_cnt    <= '0;
            ctl_q       <= '0;
            instr_count <= '0;
            imem_en     <= 1'b0;
            ir_load     <= 1'b0;
            dmem_en     <= 1'b0;
            dmem_we     <= 1'b0;
            rf_we       <= 1'b0;
            pc_we       <= 1'b0;
            out_we      <= 1'b0;
            halted      <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make each strobe a one-cycle
            // pulse unless the branch below re-asserts it; later writes win.
            imem_en <= 1'b0;
            ir_load <= 1'b0;
            dmem_en <= 1'b0;
            dmem_we <= 1'b0;
            rf_we   <= 1'b0;
            pc_we   <= 1'b0;
            out_we  <= 1'b0;
            halted  <= 1'b0;

            case (cur_state)
                S_FETCH: begin
                    // Coming out of reset the IMEM is not yet enabled; that
                    // cycle does not count toward the fetch latency.
                    if (!imem_en) begin
                        imem_en <= 1'b1;
                    end else if (wait_cnt == FETCH_LAST) begin
                        wait_cnt  <= '0;
                        cur_state <= S_DECODE;
                        ir_load   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        imem_en  <= 1'b1;
                    end
                end

                S_DECODE: begin
                    cur_state <= S_EXEC;
                end

                S_EXEC: begin
                    ctl_q <= {mem_read, mem_write, reg_write};
                    if (halt_req) begin
                        cur_state   <= S_HALT;
                        halted      <= 1'b1;
                        instr_count <= sat_inc(instr_count);
                    end else if (mem_read || mem_write) begin
                        cur_state <= S_MEM;
                        dmem_en   <= 1'b1;
                        dmem_we   <= mem_write;
                    end else begin
                        cur_state <= S_WB;
                        rf_we     <= reg_write;
                        pc_we     <= 1'b1;
                        out_we    <= 1'b1;
                    end
                end

                S_MEM: begin
                    if (wait_cnt == MEM_LAST) begin
                        wait_cnt  <= '0;
                        cur_state <= S_WB;
                        rf_we     <= ctl_q.reg_write;
                        pc_we     <= 1'b1;
                        out_we    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        dmem_en  <= ctl_q.mem_read | ctl_q.mem_write;
                    end
                end

                S_WB: begin
                    instr_count <= sat_inc(instr_count);
                    if (run) begin
                        cur_state <= S_FETCH;
                        imem_en   <= 1'b1;
                    end else begin
                        cur_state <= S_PAUSE;
                    end
                end

                S_PAUSE: begin
                    if (cont_edge) begin
                        cur_state <= S_FETCH;
                        imem_en   <= 1'b1;
                    end
                end

                S_HALT: begin
                    // Resume takes one extra HALT cycle to step the PC past
                    // the halt instruction before the next fetch reads it.
                    if (pc_we) begin
                        cur_state <= S_FETCH;
                        imem_en   <= 1'b1;
                    end else begin
                        halted <= 1'b1;
                        pc_we  <= cont_edge;
                    end
                end

                default: begin
                    cur_state <= S_FETCH;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Cycle-by-cycle check of the sequencer against an instruction-level model
// that expands each instruction into its expected stage/strobe trace.
module tb_exec_sequencer;

    localparam int IMEM_LAT = 1;
    localparam int DMEM_LAT = 2;
    localparam int CNT_W    = 4;
    localparam int OBS_W    = 3 + 7 + 1 + CNT_W;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_PAUSE  = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    // Strobe vector order: imem_en ir_load dmem_en dmem_we rf_we pc_we out_we
    localparam logic [6:0] STB_NONE = 7'b0000000;
    localparam logic [6:0] STB_IMEM = 7'b1000000;
    localparam logic [6:0] STB_IR   = 7'b0100000;
    localparam logic [6:0] STB_DMEM = 7'b0010000;
    localparam logic [6:0] STB_DWE  = 7'b0001000;
    localparam logic [6:0] STB_RF   = 7'b0000100;
    localparam logic [6:0] STB_PC   = 7'b0000010;
    localparam logic [6:0] STB_OUT  = 7'b0000001;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_HALT  = 3;

    logic             clk;
    logic             rst;
    logic             run;
    logic             cont;
    logic             halt_req;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             imem_en;
    logic             ir_load;
    logic             dmem_en;
    logic             dmem_we;
    logic             rf_we;
    logic             pc_we;
    logic             out_we;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    int               checks;
    int               errors;
    logic [CNT_W-1:0] exp_count;
    logic             cur_halt;
    logic             cur_mr;
    logic             cur_mw;
    logic             cur_rw;
    logic             cur_run;
    logic             cont_hold;
    logic             cont_noise;

    exec_sequencer #(
        .IMEM_LAT (IMEM_LAT),
        .DMEM_LAT (DMEM_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .cont        (cont),
        .halt_req    (halt_req),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .imem_en     (imem_en),
        .ir_load     (ir_load),
        .dmem_en     (dmem_en),
        .dmem_we     (dmem_we),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .out_we      (out_we),
        .halted      (halted),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Check one cycle at the falling edge, then drive the inputs this state
    // will sample: real decode only where it matters, noise elsewhere.
    task automatic cyc(input logic [2:0] es, input logic [6:0] estb, input logic eh);
        logic [OBS_W-1:0] obs;
        logic [OBS_W-1:0] exp;
        @(negedge clk);
        obs = {state, imem_en, ir_load, dmem_en, dmem_we, rf_we, pc_we, out_we,
               halted, instr_count};
        exp = {es, estb, eh, exp_count};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL cycle_check #%0d exp_state=%0d: observed %h expected %h (state|strobes|halted|count)",
                   checks, es, obs, exp);
        end
        halt_req  = (es == S_EXEC) ? cur_halt : 1'($urandom);
        mem_read  = (es == S_EXEC) ? cur_mr   : 1'($urandom);
        mem_write = (es == S_EXEC) ? cur_mw   : 1'($urandom);
        reg_write = (es == S_EXEC) ? cur_rw   : 1'($urandom);
        run       = (es == S_WB)   ? cur_run  : 1'($urandom);
        cont      = (cont_noise && (es == S_FETCH || es == S_DECODE)) ?
                    1'($urandom) : cont_hold;
    endtask

    task automatic pause_resume(input int n_high, input int n_low);
        repeat (n_high) cyc(S_PAUSE, STB_NONE, 1'b0);
        cont_hold = 1'b0;
        repeat (n_low) cyc(S_PAUSE, STB_NONE, 1'b0);
        cont_hold = 1'b1;
        cyc(S_PAUSE, STB_NONE, 1'b0);
    endtask

    task automatic do_instr(input int kind, input logic rw, input logic r);
        cur_halt = (kind == K_HALT);
        cur_mr   = (kind == K_LOAD);
        cur_mw   = (kind == K_STORE) || (kind == K_HALT);
        cur_rw   = rw;
        cur_run  = r;
        repeat (IMEM_LAT) cyc(S_FETCH, STB_IMEM, 1'b0);
        cyc(S_DECODE, STB_IR, 1'b0);
        if (cur_halt) cont_hold = 1'b1;
        cyc(S_EXEC, STB_NONE, 1'b0);
        if (cur_halt) begin
            exp_count = bump(exp_count);
            repeat (10) cyc(S_HALT, STB_NONE, 1'b1);
            cont_hold = 1'b0;
            cyc(S_HALT, STB_NONE, 1'b1);
            cont_hold = 1'b1;
            cyc(S_HALT, STB_NONE, 1'b1);
            cyc(S_HALT, STB_PC, 1'b1);
        end else begin
            if (cur_mr || cur_mw) begin
                for (int i = 0; i < DMEM_LAT; i++)
                    cyc(S_MEM, STB_DMEM | ((i == 0 && cur_mw) ? STB_DWE : STB_NONE), 1'b0);
            end
            cyc(S_WB, STB_PC | STB_OUT | (rw ? STB_RF : STB_NONE), 1'b0);
            exp_count = bump(exp_count);
        end
    endtask

    task automatic rand_instr();
        int   pick;
        int   kind;
        logic r;
        pick = int'($urandom_range(0, 9));
        kind = (pick < 5) ? K_ALU : (pick < 7) ? K_LOAD : (pick < 9) ? K_STORE : K_HALT;
        r    = 1'($urandom);
        do_instr(kind, 1'($urandom), r);
        if (!r && kind != K_HALT) pause_resume(0, int'($urandom_range(1, 3)));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_count  = '0;
        cur_halt   = 1'b0;
        cur_mr     = 1'b0;
        cur_mw     = 1'b0;
        cur_rw     = 1'b0;
        cur_run    = 1'b1;
        cont_hold  = 1'b0;
        cont_noise = 1'b1;
        rst        = 1'b0;
        run        = 1'b1;
        cont       = 1'b0;
        halt_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;

        // Reset state: FETCH, no strobes, count zero.
        @(posedge clk);
        repeat (3) cyc(S_FETCH, STB_NONE, 1'b0);
        rst = 1'b1;

        // Free-running ALU ops: four cycles each, count 1,2,3.
        repeat (3) do_instr(K_ALU, 1'b1, 1'b1);

        // Load with two-cycle DMEM, then store with rf write suppressed.
        do_instr(K_LOAD, 1'b1, 1'b1);
        do_instr(K_STORE, 1'b0, 1'b1);

        // Halt beats a pending store; resume after a long held button.
        do_instr(K_HALT, 1'b1, 1'b1);
        do_instr(K_ALU, 1'b1, 1'b1);

        repeat (8) rand_instr();

        // Single-step mode: one instruction per button edge.
        repeat (4) begin
            do_instr(K_ALU, 1'($urandom), 1'b0);
            pause_resume(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
        end

        // Reset asserted in the first MEM cycle of a store abandons it.
        cur_halt = 1'b0;
        cur_mr   = 1'b0;
        cur_mw   = 1'b1;
        cur_rw   = 1'b1;
        cur_run  = 1'b1;
        repeat (IMEM_LAT) cyc(S_FETCH, STB_IMEM, 1'b0);
        cyc(S_DECODE, STB_IR, 1'b0);
        cyc(S_EXEC, STB_NONE, 1'b0);
        cyc(S_MEM, STB_DMEM | STB_DWE, 1'b0);
        rst       = 1'b0;
        exp_count = '0;
        cyc(S_FETCH, STB_NONE, 1'b0);
        rst = 1'b1;

        // Button held high across reset release yields no step from PAUSE.
        cont_noise = 1'b0;
        cont_hold  = 1'b1;
        cont       = 1'b1;
        rst        = 1'b0;
        exp_count  = '0;
        repeat (2) cyc(S_FETCH, STB_NONE, 1'b0);
        rst = 1'b1;
        do_instr(K_ALU, 1'b1, 1'b0);
        pause_resume(5, 2);
        cont_noise = 1'b1;

        // Enough retirements to drive the narrow counter into saturation.
        repeat (20) rand_instr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
